// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and defaults for the memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GNT_CPU = 2'd1,
        S_GNT_VID = 2'd2,
        S_DONE    = 2'd3
    } state_e;
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VID = 1'b1
    } owner_e;
    localparam int VID_BURST_MAX_DEF = 4;
    localparam int BURST_W = 4;
endpackage

// File: rtl/arb_req_latch.sv
// arb_req_latch: captures CPU request pulses, holds them pending and flags protocol misuse
module arb_req_latch
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_half,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              clr,
    output logic              pend,
    output logic              we,
    output logic              half,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    output logic              proto_err
);
    logic              pend_q, pend_d, we_q, we_d, half_q, half_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              pulse, take;

    // accept a pulse only when nothing is outstanding; a read+write collision becomes a write
    always_comb begin
        pulse   = cpu_rd | cpu_wr;
        take    = pulse & ~pend_q;
        pend_d  = take | (pend_q & ~clr);
        we_d    = take ? cpu_wr : we_q;
        half_d  = take ? cpu_half : half_q;
        addr_d  = take ? cpu_addr : addr_q;
        wdata_d = take ? cpu_wdata : wdata_q;
        err_d   = err_q | (pulse & pend_q) | (cpu_rd & cpu_wr);
    end

    // request registers; pending state is lost on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            half_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            we_q    <= we_d;
            half_q  <= half_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign pend      = pend_q;
    assign we        = we_q;
    assign half      = half_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign proto_err = err_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the main-memory port between the CPU and the video scan-out reader
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int VID_BURST_MAX = VID_BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_half,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ok,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [31:0]       vid_rdata,
    output logic              vid_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_half,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              proto_err
);
    state_e               state_q, state_d;
    owner_e               owner_q, owner_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [ADDR_W-1:0]    vid_addr_q, vid_addr_d;
    logic [31:0]          cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;
    logic                 cpu_pend, cpu_we, cpu_half_q;
    logic [ADDR_W-1:0]    cpu_addr_q;
    logic [31:0]          cpu_wdata_q;
    logic                 cpu_go;

    arb_req_latch #(.ADDR_W(ADDR_W)) u_latch (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_half  (cpu_half),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .clr       (cpu_ok),
        .pend      (cpu_pend),
        .we        (cpu_we),
        .half      (cpu_half_q),
        .addr      (cpu_addr_q),
        .wdata     (cpu_wdata_q),
        .proto_err (proto_err)
    );

    assign cpu_go = cpu_pend && (!vid_req || int'(burst_q) >= VID_BURST_MAX);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next state: CPU wins unless video is asking and has not used up its burst allowance
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:               state_d = cpu_go ? S_GNT_CPU : (vid_req ? S_GNT_VID : S_IDLE);
            S_GNT_CPU, S_GNT_VID: state_d = mem_ready ? S_DONE : state_q;
            default:              state_d = S_IDLE;
        endcase
    end

    // grant bookkeeping and read-data capture
    always_comb begin
        owner_d     = owner_q;
        burst_d     = burst_q;
        vid_addr_d  = vid_addr_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        if (state_q == S_IDLE && cpu_go) begin
            owner_d = OWN_CPU;
            burst_d = '0;
        end else if (state_q == S_IDLE && vid_req) begin
            owner_d    = OWN_VID;
            vid_addr_d = vid_addr;
            burst_d    = !cpu_pend ? '0 : (burst_q == '1 ? burst_q : burst_q + 1'b1);
        end
        if (state_q == S_GNT_CPU && mem_ready && !cpu_we) cpu_rdata_d = mem_rdata;
        if (state_q == S_GNT_VID && mem_ready) vid_rdata_d = mem_rdata;
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_CPU;
            burst_q     <= '0;
            vid_addr_q  <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            vid_addr_q  <= vid_addr_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    // memory drive and completion pulses decoded from registered state only
    always_comb begin
        mem_en    = (state_q == S_GNT_CPU) || (state_q == S_GNT_VID);
        mem_we    = (state_q == S_GNT_CPU) && cpu_we;
        mem_half  = (state_q == S_GNT_CPU) && cpu_half_q;
        mem_addr  = (state_q == S_GNT_CPU) ? cpu_addr_q : ((state_q == S_GNT_VID) ? vid_addr_q : '0);
        mem_wdata = (state_q == S_GNT_CPU) ? cpu_wdata_q : '0;
        cpu_ok    = (state_q == S_DONE) && (owner_q == OWN_CPU);
        vid_ack   = (state_q == S_DONE) && (owner_q == OWN_VID);
    end

    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural memory and video requester
module tb_mem_port_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic        cpu_rd = 0, cpu_wr = 0, cpu_half = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
    logic        cpu_ok;
    logic        vid_req, vid_ack;
    logic [31:0] vid_addr, vid_rdata;
    logic        mem_en, mem_we, mem_half, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        proto_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        we;
        logic        half;
    } cpu_exp_t;

    cpu_exp_t    cpu_q[$];
    logic [31:0] vid_q[$];
    int          vectors = 0, miscompares = 0;
    int          n_cpu_ok = 0, n_vid_ack = 0;
    logic [31:0] model_rdata = 0, exp_vid_rdata = 0;
    int          lat_cfg = 1;
    bit          rand_lat = 0, spur = 0, vid_on = 0;
    int          vid_rate = 100;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_half  (cpu_half),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ok    (cpu_ok),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_rdata (vid_rdata),
        .vid_ack   (vid_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_half  (mem_half),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // memory: answers after a configurable number of extra cycles, or asserts a stray ready
    initial begin
        int  wait_left;
        bit  in_acc;
        in_acc = 0;
        wait_left = 0;
        mem_ready = 0;
        mem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 0;
            if (spur) begin
                mem_ready = 1;
                mem_rdata = 32'hBAD0BAD0;
            end else if (mem_en) begin
                if (!in_acc) begin
                    in_acc = 1;
                    wait_left = rand_lat ? int'($urandom_range(1, 3)) : lat_cfg;
                end
                if (wait_left == 0) begin
                    mem_ready = 1;
                    mem_rdata = mem_fn(mem_addr);
                    in_acc = 0;
                end else wait_left--;
            end else in_acc = 0;
        end
    end

    // video requester: level request held until ack, dropped in the ack cycle
    initial begin
        vid_req = 0;
        vid_addr = 0;
        forever begin
            @(posedge clk); #1;
            if (rst || vid_ack) vid_req = 0;
            else if (!vid_req && vid_on && $urandom_range(0, 99) < vid_rate) begin
                vid_req = 1;
                vid_addr = 32'h10000 | ($urandom & 32'hFFFC);
                vid_q.push_back(vid_addr);
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT completes an access
    initial begin
        cpu_exp_t    e;
        logic [31:0] va, acc_addr, acc_wdata;
        logic        acc_we, acc_half;
        acc_addr = 0; acc_wdata = 0; acc_we = 0; acc_half = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_en && mem_ready) begin
                    acc_addr = mem_addr; acc_wdata = mem_wdata; acc_we = mem_we; acc_half = mem_half;
                end
                if (cpu_ok || vid_ack) chk("ok_ack_exclusive", {31'b0, cpu_ok & vid_ack}, 0);
                if (cpu_ok) begin
                    n_cpu_ok++;
                    chk("cpu_ok_expected", {31'b0, cpu_q.size() != 0}, 1);
                    if (cpu_q.size() != 0) begin
                        e = cpu_q.pop_front();
                        chk("cpu_mem_addr", acc_addr, e.addr);
                        chk("cpu_mem_we", {31'b0, acc_we}, {31'b0, e.we});
                        chk("cpu_mem_half", {31'b0, acc_half}, {31'b0, e.half});
                        if (e.we) chk("cpu_mem_wdata", acc_wdata, e.wdata);
                        chk("cpu_rdata", cpu_rdata, e.rdata);
                    end
                end
                if (vid_ack) begin
                    n_vid_ack++;
                    chk("vid_ack_expected", {31'b0, vid_q.size() != 0}, 1);
                    if (vid_q.size() != 0) begin
                        va = vid_q.pop_front();
                        exp_vid_rdata = mem_fn(va);
                        chk("vid_mem_addr", acc_addr, va);
                        chk("vid_mem_we", {31'b0, acc_we}, 0);
                        chk("vid_rdata", vid_rdata, exp_vid_rdata);
                    end
                end
            end
        end
    end

    task automatic cpu_issue(input logic rd, input logic wr, input logic half,
                             input logic [31:0] a, input logic [31:0] wd, input bit push);
        cpu_exp_t e;
        @(posedge clk); #1;
        cpu_rd = rd; cpu_wr = wr; cpu_half = half; cpu_addr = a; cpu_wdata = wd;
        if (push) begin
            if (!wr) model_rdata = mem_fn(a);
            e.addr = a; e.wdata = wd; e.we = wr; e.half = half; e.rdata = model_rdata;
            cpu_q.push_back(e);
        end
        @(posedge clk); #1;
        cpu_rd = 0; cpu_wr = 0;
    endtask

    task automatic wait_ok(input int target);
        int k = 0;
        while (n_cpu_ok < target && k < 300) begin @(negedge clk); #1; k++; end
        chk("cpu_ok_within_budget", {31'b0, n_cpu_ok >= target}, 1);
    endtask

    task automatic quiesce();
        int k = 0;
        while ((cpu_q.size() != 0 || vid_q.size() != 0 || vid_req || mem_en) && k < 400) begin
            @(negedge clk); #1; k++;
        end
        chk("quiesce_within_budget", {31'b0, k < 400}, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int c0, v0, k;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_cpu_ok", {31'b0, cpu_ok}, 0);
        chk("rst_vid_ack", {31'b0, vid_ack}, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_vid_rdata", vid_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_proto_err", {31'b0, proto_err}, 0);
        rst = 0;
        repeat (2) @(posedge clk);

        // CPU read latency with memory answering in the second mem_en cycle
        lat_cfg = 1;
        c0 = n_cpu_ok;
        @(posedge clk); #1;
        cpu_rd = 1; cpu_addr = 32'h100; cpu_wdata = 0; cpu_half = 0;
        model_rdata = 32'hDEADBEEF;
        cpu_q.push_back('{addr: 32'h100, wdata: 32'h0, rdata: 32'hDEADBEEF, we: 1'b0, half: 1'b0});
        @(posedge clk); #1; cpu_rd = 0;
        chk("lat_t1_mem_en", {31'b0, mem_en}, 0);
        @(posedge clk); #1;
        chk("lat_t2_mem_en", {31'b0, mem_en}, 1);
        chk("lat_t2_mem_addr", mem_addr, 32'h100);
        @(posedge clk); #1;
        chk("lat_t3_mem_en", {31'b0, mem_en}, 1);
        @(posedge clk); #1;
        chk("lat_t4_cpu_ok", {31'b0, cpu_ok}, 1);
        chk("lat_t4_mem_en", {31'b0, mem_en}, 0);
        chk("lat_t4_vid_ack", {31'b0, vid_ack}, 0);
        chk("lat_t4_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        wait_ok(c0 + 1);

        // halfword write
        c0 = n_cpu_ok;
        cpu_issue(0, 1, 1, 32'h204, 32'h0000ABCD, 1);
        k = 0;
        while (!mem_en && k < 20) begin @(negedge clk); k++; end
        chk("hw_mem_we", {31'b0, mem_we}, 1);
        chk("hw_mem_half", {31'b0, mem_half}, 1);
        chk("hw_mem_addr", mem_addr, 32'h204);
        chk("hw_mem_wdata", mem_wdata, 32'h0000ABCD);
        wait_ok(c0 + 1);
        repeat (5) @(negedge clk);
        chk("hw_single_ok", n_cpu_ok, c0 + 1);
        chk("hw_rdata_kept", cpu_rdata, 32'hDEADBEEF);

        // stray mem_ready while idle
        quiesce();
        c0 = n_cpu_ok; v0 = n_vid_ack;
        @(negedge clk); spur = 1;
        repeat (4) @(negedge clk);
        spur = 0;
        repeat (3) @(negedge clk);
        chk("spur_no_ok", n_cpu_ok, c0);
        chk("spur_no_ack", n_vid_ack, v0);
        chk("spur_cpu_rdata", cpu_rdata, model_rdata);
        chk("spur_vid_rdata", vid_rdata, exp_vid_rdata);

        // CPU and continuous video contend: video gets its burst, then the CPU, then video again
        vid_rate = 100;
        c0 = n_cpu_ok; v0 = n_vid_ack;
        @(posedge clk); #1;
        cpu_rd = 1; cpu_addr = 32'h500; cpu_half = 0;
        model_rdata = mem_fn(32'h500);
        cpu_q.push_back('{addr: 32'h500, wdata: 32'h0, rdata: model_rdata, we: 1'b0, half: 1'b0});
        @(negedge clk); vid_on = 1;
        @(posedge clk); #1; cpu_rd = 0;
        wait_ok(c0 + 1);
        chk("burst_vid_acks", n_vid_ack - v0, 4);
        k = 0;
        while (n_vid_ack < v0 + 5 && k < 50) begin @(negedge clk); #1; k++; end
        chk("video_resumes", {31'b0, n_vid_ack >= v0 + 5}, 1);
        @(negedge clk); vid_on = 0;
        quiesce();

        // second pulse while the first is in service
        lat_cfg = 2;
        c0 = n_cpu_ok;
        chk("perr_before", {31'b0, proto_err}, 0);
        cpu_issue(1, 0, 0, 32'h300, 32'h0, 1);
        cpu_issue(1, 0, 0, 32'h400, 32'h0, 0);
        wait_ok(c0 + 1);
        repeat (10) @(negedge clk);
        chk("perr_single_ok", n_cpu_ok, c0 + 1);
        chk("perr_set", {31'b0, proto_err}, 1);
        repeat (5) @(negedge clk);
        chk("perr_sticky", {31'b0, proto_err}, 1);

        // reset during a video access
        quiesce();
        lat_cfg = 6;
        v0 = n_vid_ack;
        @(negedge clk); vid_on = 1;
        k = 0;
        while (!mem_en && k < 20) begin @(negedge clk); k++; end
        chk("rstmid_granted", {31'b0, mem_en}, 1);
        @(posedge clk); #3;
        rst = 1; vid_on = 0;
        #1;
        chk("rstmid_mem_en", {31'b0, mem_en}, 0);
        chk("rstmid_vid_ack", {31'b0, vid_ack}, 0);
        vid_q.delete();
        repeat (3) @(negedge clk);
        rst = 0;
        model_rdata = 0; exp_vid_rdata = 0;
        chk("rstmid_no_ack", n_vid_ack, v0);
        chk("rstmid_proto_err", {31'b0, proto_err}, 0);
        chk("rstmid_vid_rdata", vid_rdata, 0);
        lat_cfg = 1;
        c0 = n_cpu_ok;
        cpu_issue(1, 0, 0, 32'h600, 32'h0, 1);
        wait_ok(c0 + 1);

        // simultaneous read and write pulse: treated as a write
        c0 = n_cpu_ok;
        cpu_issue(1, 1, 0, 32'h700, 32'h12345678, 1);
        wait_ok(c0 + 1);
        chk("rdwr_proto_err", {31'b0, proto_err}, 1);

        // randomized traffic with random memory latency and intermittent video
        rand_lat = 1; vid_rate = 40;
        @(negedge clk); vid_on = 1;
        for (int i = 0; i < 30; i++) begin
            logic rd;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            rd = 1'($urandom_range(0, 1));
            c0 = n_cpu_ok;
            cpu_issue(rd, !rd, 1'($urandom_range(0, 1)), $urandom & 32'h0000FFFC, $urandom, 1);
            wait_ok(c0 + 1);
        end
        @(negedge clk); vid_on = 0;
        quiesce();
        chk("final_proto_err", {31'b0, proto_err}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
